// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction sequencer: FSM encoding, request entry
// layout and rw constants.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BUSY  = 3'd2,
    S_RESP  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  localparam int REQ_W = 40;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef struct packed {
    logic [6:0]  addr;
    logic        rw;
    logic [31:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// System-side request/response channels of the I2C transaction sequencer.
interface i2c_txn_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_addr;
  logic        req_rw;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_rw;
  logic        rsp_err;

  // slave: the sequencer; master: the system-side requester
  modport slave (
    input  req_valid, req_addr, req_rw, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_rw, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_rw, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rw, rsp_err
  );
endinterface

// File: rtl/i2c_req_fifo.sv
// Synchronous request FIFO, registered storage, extra pointer bit for full/empty.
module i2c_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Queues read/write requests and feeds them one at a time to the I2C master,
// with issue/busy timeouts and an enforced idle gap so the master always STOPs.
// A slave NACK is invisible here: the master simply returns to ready and the
// transfer is reported as a normal completion carrying whatever data_in holds.
//
//   state   | meaning
//   S_IDLE  | waiting for a queued request and master ready
//   S_ISSUE | m_enable held, waiting for master ready to fall
//   S_BUSY  | master running, waiting for ready to return
//   S_RESP  | response presented, waiting for rsp_ready
//   S_GAP   | bus free time before the next issue
module i2c_txn_sequencer
  import i2c_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int ISSUE_TIMEOUT = 64,
  parameter int BUSY_TIMEOUT  = 4096,
  parameter int GAP_CYCLES    = 8
) (
  input  logic        clk,
  input  logic        rst,
  i2c_txn_sequencer_if.slave sys,
  output logic [6:0]  m_addr,
  output logic        m_rw,
  output logic [31:0] m_data_out,
  output logic        m_enable,
  input  logic [31:0] m_data_in,
  input  logic        m_ready,
  output logic        busy
);

  localparam int MAX_A = (ISSUE_TIMEOUT > BUSY_TIMEOUT) ? ISSUE_TIMEOUT : BUSY_TIMEOUT;
  localparam int MAX_T = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(ISSUE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              rdy_meta_q, rdy_s_q;
  logic              ready_en_q;
  logic [6:0]        m_addr_q, m_addr_d;
  logic              m_rw_q, m_rw_d;
  logic [31:0]       m_data_q, m_data_d;
  logic              m_enable_q, m_enable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              req_ready;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  req_entry_t        fifo_wdata, fifo_rdata;

  // req_ready held low until the first clock after reset release
  assign req_ready   = ready_en_q & ~fifo_full;
  assign fifo_push   = sys.req_valid & req_ready;
  assign fifo_wdata  = {sys.req_addr, sys.req_rw, sys.req_wdata};

  i2c_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    m_addr_d    = m_addr_q;
    m_rw_d      = m_rw_q;
    m_data_d    = m_data_q;
    m_enable_d  = m_enable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;

    case (state_q)
      S_IDLE: begin
        m_enable_d = 1'b0;
        if (!fifo_empty && rdy_s_q) begin
          fifo_pop   = 1'b1;
          m_addr_d   = fifo_rdata.addr;
          m_rw_d     = fifo_rdata.rw;
          m_data_d   = fifo_rdata.wdata;
          m_enable_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_inc;
        if (!rdy_s_q) begin
          m_enable_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_BUSY;
        end else if (cnt_q == ISSUE_LAST) begin
          m_enable_d  = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_inc;
        if (rdy_s_q) begin
          rsp_rdata_d = (m_rw_q == RW_READ) ? m_data_in : '0;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == BUSY_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (sys.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_inc;
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      default: begin
        m_enable_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rdy_meta_q  <= 1'b0;
      rdy_s_q     <= 1'b0;
      ready_en_q  <= 1'b0;
      m_addr_q    <= '0;
      m_rw_q      <= 1'b0;
      m_data_q    <= '0;
      m_enable_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdy_meta_q  <= m_ready;
      rdy_s_q     <= rdy_meta_q;
      ready_en_q  <= 1'b1;
      m_addr_q    <= m_addr_d;
      m_rw_q      <= m_rw_d;
      m_data_q    <= m_data_d;
      m_enable_q  <= m_enable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign m_addr        = m_addr_q;
  assign m_rw          = m_rw_q;
  assign m_data_out    = m_data_q;
  assign m_enable      = m_enable_q;
  assign sys.req_ready = req_ready;
  assign sys.rsp_valid = rsp_valid_q;
  assign sys.rsp_rdata = rsp_rdata_q;
  assign sys.rsp_rw    = m_rw_q;
  assign sys.rsp_err   = rsp_err_q;
  assign busy          = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Scoreboard bench for i2c_txn_sequencer with a behavioural I2C master model.
module tb_i2c_txn_sequencer;

  localparam int FIFO_DEPTH    = 4;
  localparam int ISSUE_TIMEOUT = 64;
  localparam int BUSY_TIMEOUT  = 4096;
  localparam int GAP_CYCLES    = 8;
  localparam int XFER_CYCLES   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  m_addr;
  logic        m_rw;
  logic [31:0] m_data_out;
  logic        m_enable;
  logic [31:0] m_data_in;
  logic        m_ready;
  logic        busy;

  i2c_txn_sequencer_if sys_if();

  i2c_txn_sequencer #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .ISSUE_TIMEOUT (ISSUE_TIMEOUT),
    .BUSY_TIMEOUT  (BUSY_TIMEOUT),
    .GAP_CYCLES    (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sys        (sys_if),
    .m_addr     (m_addr),
    .m_rw       (m_rw),
    .m_data_out (m_data_out),
    .m_enable   (m_enable),
    .m_data_in  (m_data_in),
    .m_ready    (m_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int stop_cnt = 0;
  int en_len = 0;
  int mdl_mode = 0;  // 0 normal, 1 never drops ready, 2 holds ready low until released

  logic [39:0] exp_iss[$];
  logic [33:0] exp_rsp[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [31:0] slave_rd(input logic [6:0] a);
    return (a == 7'h3C) ? 32'h1234_5678 : {24'hA5A5A5, 1'b0, a};
  endfunction

  // Master/slave model
  initial begin
    int n;
    int w;
    logic [6:0] cur_addr;
    m_ready   = 1'b1;
    m_data_in = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (m_enable && m_ready && mdl_mode != 1) begin
        cur_addr = m_addr;
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b0;
        n = 0;
        while (m_enable && n < 10) begin
          @(posedge clk); #1;
          n++;
        end
        chk("en_drop_le3", 64'(n <= 3), 64'd1);
        if (mdl_mode == 2) begin
          w = 0;
          while (mdl_mode == 2 && w < 20000) begin
            @(posedge clk); #1;
            w++;
          end
        end else begin
          repeat (XFER_CYCLES) @(posedge clk);
          #1;
        end
        m_data_in = slave_rd(cur_addr);
        chk("no_rechain", 64'(m_enable), 64'd0);
        m_ready = 1'b1;
        stop_cnt++;
      end
    end
  end

  // Issue monitor
  initial begin
    logic en_prev = 1'b0;
    logic have_fall = 1'b0;
    int   cyc = 0;
    int   last_fall = 0;
    logic [39:0] e;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (m_enable && !en_prev) begin
        if (exp_iss.size() == 0) begin
          bound_fail("unexpected_issue");
        end else begin
          e = exp_iss.pop_front();
          chk("issue_fields", {24'h0, m_addr, m_rw, m_data_out}, {24'h0, e});
        end
        if (have_fall) chk("gap_ge", 64'((cyc - last_fall) >= GAP_CYCLES), 64'd1);
        en_len = 0;
      end
      if (m_enable) en_len++;
      if (!m_enable && en_prev) begin
        last_fall = cyc;
        have_fall = 1'b1;
      end
      en_prev = m_enable;
    end
  end

  // Response monitor
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (sys_if.rsp_valid && sys_if.rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          bound_fail("unexpected_response");
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp", {30'h0, sys_if.rsp_rdata, sys_if.rsp_rw, sys_if.rsp_err}, {30'h0, e});
        end
      end
    end
  end

  task automatic push_req(input logic [6:0] a, input logic rw, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
    logic ok;
    exp_iss.push_back({a, rw, wd});
    exp_rsp.push_back({exp_rd, rw, exp_err});
    sys_if.req_valid = 1'b1;
    sys_if.req_addr  = a;
    sys_if.req_rw    = rw;
    sys_if.req_wdata = wd;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = sys_if.req_ready;
      @(posedge clk); #1;
    end
    sys_if.req_valid = 1'b0;
    if (!ok) bound_fail("push_accept");
  endtask

  task automatic wait_done(input int max_cyc);
    int i;
    i = 0;
    while ((exp_rsp.size() != 0 || busy) && i < max_cyc) begin
      @(posedge clk); #1;
      i++;
    end
    if (i >= max_cyc) bound_fail("wait_done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst = 1'b0;
    sys_if.req_valid = 1'b0;
    sys_if.req_addr  = '0;
    sys_if.req_rw    = 1'b0;
    sys_if.req_wdata = '0;
    sys_if.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(sys_if.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(sys_if.rsp_rdata), 64'd0);
    chk("rst_rsp_rw", 64'(sys_if.rsp_rw), 64'd0);
    chk("rst_rsp_err", 64'(sys_if.rsp_err), 64'd0);
    chk("rst_m_enable", 64'(m_enable), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_m_data_out", 64'(m_data_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(sys_if.req_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_rst", 64'(sys_if.req_ready), 64'd1);

    // single write
    sys_if.rsp_ready = 1'b1;
    push_req(7'h50, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    wait_done(500);
    chk("one_stop", 64'(stop_cnt), 64'd1);

    // single read
    push_req(7'h3C, 1'b1, 32'h0, 32'h1234_5678, 1'b0);
    wait_done(500);

    // back-pressure with response channel stalled
    sys_if.rsp_ready = 1'b0;
    push_req(7'h10, 1'b0, 32'h1111_1111, 32'h0, 1'b0);
    push_req(7'h11, 1'b1, 32'h0, 32'hA5A5_A511, 1'b0);
    push_req(7'h12, 1'b0, 32'h3333_3333, 32'h0, 1'b0);
    push_req(7'h3C, 1'b1, 32'h0, 32'h1234_5678, 1'b0);
    push_req(7'h13, 1'b0, 32'h5555_5555, 32'h0, 1'b0);
    chk("fifo_full_ready_low", 64'(sys_if.req_ready), 64'd0);
    repeat (60) @(posedge clk);
    #1;
    chk("rsp_held", 64'(sys_if.rsp_valid), 64'd1);
    chk("rsp_held_rw", 64'(sys_if.rsp_rw), 64'd0);
    sys_if.rsp_ready = 1'b1;
    wait_done(3000);

    // issue timeout: master never drops ready
    mdl_mode = 1;
    push_req(7'h22, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b1);
    wait_done(500);
    chk("issue_en_len", 64'(en_len), 64'(ISSUE_TIMEOUT));
    chk("issue_en_low", 64'(m_enable), 64'd0);
    mdl_mode = 0;

    // busy timeout, then the queued request proceeds once ready returns
    mdl_mode = 2;
    push_req(7'h23, 1'b1, 32'h0, 32'h0, 1'b1);
    push_req(7'h24, 1'b0, 32'h0BAD_F00D, 32'h0, 1'b0);
    i = 0;
    while (exp_rsp.size() > 1 && i < 6000) begin
      @(posedge clk); #1;
      i++;
    end
    if (i >= 6000) bound_fail("busy_timeout_rsp");
    repeat (20) @(posedge clk);
    #1;
    chk("hold_while_low_en", 64'(m_enable), 64'd0);
    chk("hold_while_low_busy", 64'(busy), 64'd1);
    chk("second_not_issued", 64'(exp_iss.size()), 64'd1);
    mdl_mode = 0;
    wait_done(1000);

    // reset in S_BUSY with two entries queued
    mdl_mode = 2;
    push_req(7'h30, 1'b0, 32'h0101_0101, 32'h0, 1'b0);
    push_req(7'h31, 1'b1, 32'h0, 32'h0, 1'b0);
    push_req(7'h32, 1'b0, 32'h0303_0303, 32'h0, 1'b0);
    i = 0;
    while (!((m_ready == 1'b0) && (m_enable == 1'b0)) && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    if (i >= 200) bound_fail("reach_busy");
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    exp_iss.delete();
    exp_rsp.delete();
    #1;
    chk("mid_rst_en", 64'(m_enable), 64'd0);
    chk("mid_rst_rsp_valid", 64'(sys_if.rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_req_ready", 64'(sys_if.req_ready), 64'd0);
    chk("mid_rst_m_addr", 64'(m_addr), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    mdl_mode = 0;
    repeat (60) @(posedge clk);
    #1;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_req_ready", 64'(sys_if.req_ready), 64'd1);
    chk("post_rst_en", 64'(m_enable), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
